fft_stream_io: RTL and testbench

- Streaming front/back end for the 4-bank radix-4 FFT core. Lives in the same top as the core and drives its external-source path.
- Loads a frame of ADC samples, arriving over a valid/ready handshake, into the four RAM_A banks. Then pulses the FFT start and waits for completion.
- Finally streams the N real-part results out, in natural bin order, over a valid/ready handshake.
- Parametrised successor of the fixed 16/17-bit, fixed-depth loading path: width, depth and input-overflow mode are configurable, and the block adds backpressure and a drop counter.

---
 rtl/fft_stream_io_if.sv | 44 ++++
 rtl/fft_stream_io.sv | 182 ++++++++++++++++++
 tb/tb_fft_stream_io.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stream_io_if.sv
// Signal bundle of fft_stream_io: sample stream in, RAM_A port, FFT control
// handshake and result stream out. master = the streaming block, slave = its environment.
interface fft_stream_io_if #(
    parameter int IN_BIT  = 16,
    parameter int D_BIT   = 17,
    parameter int A_BIT   = 8,
    parameter int CNT_BIT = 16
);
    logic signed [IN_BIT-1:0] iSAMPLE;
    logic                     iSAMPLE_VALID;
    logic                     oSAMPLE_READY;
    logic                     oSOURCE_CONT;
    logic [D_BIT-1:0]         oDATA;
    logic [A_BIT-1:0]         oADDR_WR;
    logic [3:0]               oWE;
    logic [A_BIT-1:0]         oADDR_RD;
    logic [D_BIT-1:0]         iRAM_RE_0;
    logic [D_BIT-1:0]         iRAM_RE_1;
    logic [D_BIT-1:0]         iRAM_RE_2;
    logic [D_BIT-1:0]         iRAM_RE_3;
    logic                     oFFT_START;
    logic                     iFFT_RDY;
    logic [D_BIT-1:0]         oOUT_DATA;
    logic [A_BIT+1:0]         oOUT_INDEX;
    logic                     oOUT_VALID;
    logic                     iOUT_READY;
    logic                     oOUT_LAST;
    logic                     oBUSY;
    logic [CNT_BIT-1:0]       oDROP_CNT;

    modport master (
        input  iSAMPLE, iSAMPLE_VALID, iRAM_RE_0, iRAM_RE_1, iRAM_RE_2, iRAM_RE_3,
               iFFT_RDY, iOUT_READY,
        output oSAMPLE_READY, oSOURCE_CONT, oDATA, oADDR_WR, oWE, oADDR_RD, oFFT_START,
               oOUT_DATA, oOUT_INDEX, oOUT_VALID, oOUT_LAST, oBUSY, oDROP_CNT
    );

    modport slave (
        output iSAMPLE, iSAMPLE_VALID, iRAM_RE_0, iRAM_RE_1, iRAM_RE_2, iRAM_RE_3,
               iFFT_RDY, iOUT_READY,
        input  oSAMPLE_READY, oSOURCE_CONT, oDATA, oADDR_WR, oWE, oADDR_RD, oFFT_START,
               oOUT_DATA, oOUT_INDEX, oOUT_VALID, oOUT_LAST, oBUSY, oDROP_CNT
    );
endinterface

// File: rtl/fft_stream_io.sv
// Streaming front/back end of the 4-bank radix-4 FFT: loads one frame of samples into
// RAM_A, kicks the FFT, then streams real-part results out in natural bin order.
module fft_stream_io #(
    parameter int IN_BIT    = 16,
    parameter int D_BIT     = 17,
    parameter int A_BIT     = 8,
    parameter int DROP_MODE = 0,
    parameter int CNT_BIT   = 16
) (
    input logic            iCLK,
    input logic            iRESET,
    fft_stream_io_if.master bus
);
    localparam int K_BIT = A_BIT + 2;
    localparam logic [K_BIT-1:0]   K_LAST  = {K_BIT{1'b1}};
    localparam logic [K_BIT-1:0]   K_ONE   = K_BIT'(1);
    localparam logic [CNT_BIT-1:0] CNT_MAX = {CNT_BIT{1'b1}};
    localparam logic [CNT_BIT-1:0] CNT_ONE = CNT_BIT'(1);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_START  = 2'd1,
        S_RUN    = 2'd2,
        S_UNLOAD = 2'd3
    } state_t;

    state_t             state_r;
    logic [K_BIT-1:0]   wr_n_r;
    logic [K_BIT-1:0]   rd_k_r;
    logic               run_armed_r;
    logic               rd_done_r;
    logic               pend_v_r;
    logic [1:0]         pend_bank_r;
    logic [K_BIT-1:0]   pend_idx_r;
    logic               out_v_r;
    logic [D_BIT-1:0]   out_d_r;
    logic [K_BIT-1:0]   out_i_r;
    logic               skid_v_r;
    logic [D_BIT-1:0]   skid_d_r;
    logic [K_BIT-1:0]   skid_i_r;
    logic [CNT_BIT-1:0] drop_cnt_r;

    logic               accept_s;
    logic               pop_s;
    logic               issue_s;
    logic [1:0]         occ_s;
    logic [D_BIT-1:0]   rd_data_s;

    function automatic logic [D_BIT-1:0] sign_ext(input logic [IN_BIT-1:0] s);
        return {{(D_BIT-IN_BIT){s[IN_BIT-1]}}, s};
    endfunction

    assign accept_s = (state_r == S_LOAD) && bus.iSAMPLE_VALID;
    assign pop_s    = out_v_r && bus.iOUT_READY;
    assign issue_s  = (state_r == S_UNLOAD) && !rd_done_r && (occ_s < 2'd2);

    // Slots that stay taken after this cycle's pop, counting the read in flight.
    always_comb begin
        occ_s = 2'(out_v_r) + 2'(skid_v_r) + 2'(pend_v_r) - 2'(pop_s);
    end

    // Bank select for the read issued one cycle earlier.
    always_comb begin
        rd_data_s = '0;
        case (pend_bank_r)
            2'd0:    rd_data_s = bus.iRAM_RE_0;
            2'd1:    rd_data_s = bus.iRAM_RE_1;
            2'd2:    rd_data_s = bus.iRAM_RE_2;
            2'd3:    rd_data_s = bus.iRAM_RE_3;
            default: rd_data_s = '0;
        endcase
    end

    // Frame sequencer with the write and read counters.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_r     <= S_LOAD;
            wr_n_r      <= '0;
            rd_k_r      <= '0;
            run_armed_r <= 1'b0;
            rd_done_r   <= 1'b0;
            pend_v_r    <= 1'b0;
            pend_bank_r <= 2'd0;
            pend_idx_r  <= '0;
        end else begin
            case (state_r)
                S_LOAD: begin
                    if (accept_s) begin
                        wr_n_r <= wr_n_r + K_ONE;
                        if (wr_n_r == K_LAST) begin
                            state_r <= S_START;
                        end
                    end
                end
                S_START: begin
                    run_armed_r <= 1'b0;
                    state_r     <= S_RUN;
                end
                S_RUN: begin
                    // The first RUN cycle sees a ready level left over from the previous frame.
                    run_armed_r <= 1'b1;
                    if (run_armed_r && bus.iFFT_RDY) begin
                        state_r <= S_UNLOAD;
                    end
                end
                S_UNLOAD: begin
                    if (issue_s) begin
                        rd_k_r <= rd_k_r + K_ONE;
                        if (rd_k_r == K_LAST) begin
                            rd_done_r <= 1'b1;
                        end
                    end
                    if (pop_s && (out_i_r == K_LAST)) begin
                        state_r   <= S_LOAD;
                        rd_done_r <= 1'b0;
                    end
                end
                default: state_r <= S_LOAD;
            endcase
            pend_v_r    <= issue_s;
            pend_bank_r <= rd_k_r[1:0];
            pend_idx_r  <= rd_k_r;
        end
    end

    // Output register plus skid entry; the output only changes when empty or accepted.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            out_v_r  <= 1'b0;
            out_d_r  <= '0;
            out_i_r  <= '0;
            skid_v_r <= 1'b0;
            skid_d_r <= '0;
            skid_i_r <= '0;
        end else if (pop_s) begin
            if (skid_v_r) begin
                out_d_r  <= skid_d_r;
                out_i_r  <= skid_i_r;
                skid_v_r <= 1'b0;
            end else if (pend_v_r) begin
                out_d_r <= rd_data_s;
                out_i_r <= pend_idx_r;
            end else begin
                out_v_r <= 1'b0;
            end
        end else if (pend_v_r) begin
            if (out_v_r) begin
                skid_d_r <= rd_data_s;
                skid_i_r <= pend_idx_r;
                skid_v_r <= 1'b1;
            end else begin
                out_d_r <= rd_data_s;
                out_i_r <= pend_idx_r;
                out_v_r <= 1'b1;
            end
        end
    end

    // Saturating count of samples offered while the frame buffer is busy.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            drop_cnt_r <= '0;
        end else if ((DROP_MODE != 0) && (state_r != S_LOAD) && bus.iSAMPLE_VALID
                     && (drop_cnt_r != CNT_MAX)) begin
            drop_cnt_r <= drop_cnt_r + CNT_ONE;
        end
    end

    assign bus.oSAMPLE_READY = (state_r == S_LOAD) || (DROP_MODE != 0);
    assign bus.oSOURCE_CONT  = (state_r == S_LOAD) || (state_r == S_UNLOAD);
    assign bus.oDATA         = accept_s ? sign_ext(bus.iSAMPLE) : '0;
    assign bus.oADDR_WR      = wr_n_r[K_BIT-1:2];
    assign bus.oWE           = accept_s ? (4'b0001 << wr_n_r[1:0]) : 4'b0000;
    assign bus.oADDR_RD      = rd_k_r[K_BIT-1:2];
    assign bus.oFFT_START    = (state_r == S_START);
    assign bus.oOUT_DATA     = out_d_r;
    assign bus.oOUT_INDEX    = out_i_r;
    assign bus.oOUT_VALID    = out_v_r;
    assign bus.oOUT_LAST     = out_v_r && (out_i_r == K_LAST);
    assign bus.oBUSY         = (state_r != S_LOAD);
    assign bus.oDROP_CNT     = drop_cnt_r;
endmodule

// File: tb/tb_fft_stream_io.sv
// Scoreboard bench for fft_stream_io (N=16): a backpressure instance and a drop-mode
// instance share one stimulus stream; results are checked against a frame-level model.
module tb_fft_stream_io;
    localparam int IN_BIT = 16;
    localparam int D_BIT  = 17;
    localparam int A_BIT  = 2;

    typedef struct {
        logic [3:0]  k;
        logic [16:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic signed [15:0] sample;
    logic valid, fft_rdy, out_ready;
    logic [16:0] mem [4][4];
    logic [16:0] rdata [4];

    always #5 clk = ~clk;

    fft_stream_io_if #(.IN_BIT(IN_BIT), .D_BIT(D_BIT), .A_BIT(A_BIT), .CNT_BIT(16)) bus0();
    fft_stream_io_if #(.IN_BIT(IN_BIT), .D_BIT(D_BIT), .A_BIT(A_BIT), .CNT_BIT(2))  bus1();

    fft_stream_io #(.IN_BIT(IN_BIT), .D_BIT(D_BIT), .A_BIT(A_BIT), .DROP_MODE(0), .CNT_BIT(16))
        dut0 (.iCLK(clk), .iRESET(rst_n), .bus(bus0.master));
    fft_stream_io #(.IN_BIT(IN_BIT), .D_BIT(D_BIT), .A_BIT(A_BIT), .DROP_MODE(1), .CNT_BIT(2))
        dut1 (.iCLK(clk), .iRESET(rst_n), .bus(bus1.master));

    assign bus0.iSAMPLE = sample;      assign bus1.iSAMPLE = sample;
    assign bus0.iSAMPLE_VALID = valid; assign bus1.iSAMPLE_VALID = valid;
    assign bus0.iFFT_RDY = fft_rdy;    assign bus1.iFFT_RDY = fft_rdy;
    assign bus0.iOUT_READY = out_ready; assign bus1.iOUT_READY = out_ready;
    assign bus0.iRAM_RE_0 = rdata[0];  assign bus1.iRAM_RE_0 = rdata[0];
    assign bus0.iRAM_RE_1 = rdata[1];  assign bus1.iRAM_RE_1 = rdata[1];
    assign bus0.iRAM_RE_2 = rdata[2];  assign bus1.iRAM_RE_2 = rdata[2];
    assign bus0.iRAM_RE_3 = rdata[3];  assign bus1.iRAM_RE_3 = rdata[3];

    // RAM_A: four banks, registered read with latency 1
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus0.oWE[b]) mem[b][bus0.oADDR_WR] <= bus0.oDATA;
            rdata[b] <= mem[b][bus0.oADDR_RD];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] sx(input logic [15:0] s);
        return {s[15], s};
    endfunction

    // model state
    exp_t exp_q[$];
    logic [3:0]  n_m;
    logic        busy_m, start_next, unload_m, hold_v;
    logic [16:0] hold_d;
    logic [3:0]  hold_i;
    int lowcnt, ucyc, drop_m, pops, frames_done = 0, start_cnt = 0;
    int exp_low = 3;
    logic full_tp = 1'b0;

    // monitor: model update and all comparisons, sampled on the falling edge
    always @(negedge clk) begin
        logic acc;
        logic [3:0] ewe;
        logic last_pop;
        exp_t e;
        if (!rst_n) begin
            chk("rst_ready0", bus0.oSAMPLE_READY, 1);
            chk("rst_ready1", bus1.oSAMPLE_READY, 1);
            chk("rst_src", bus0.oSOURCE_CONT, 1);
            chk("rst_we", bus0.oWE, 0);
            chk("rst_start", bus0.oFFT_START, 0);
            chk("rst_valid", bus0.oOUT_VALID, 0);
            chk("rst_busy", bus0.oBUSY, 0);
            chk("rst_drop1", bus1.oDROP_CNT, 0);
            chk("rst_addr", {bus0.oADDR_WR, bus0.oADDR_RD}, 0);
            chk("rst_out", {bus0.oOUT_DATA, bus0.oOUT_INDEX, bus0.oOUT_LAST}, 0);
            n_m = 4'd0; busy_m = 1'b0; start_next = 1'b0; unload_m = 1'b0; hold_v = 1'b0;
            lowcnt = 0; ucyc = 0; drop_m = 0; pops = 0;
            exp_q.delete();
        end else begin
            last_pop = 1'b0;
            chk("busy", bus0.oBUSY, busy_m);
            chk("ready0", bus0.oSAMPLE_READY, !busy_m);
            chk("ready1", bus1.oSAMPLE_READY, 1);
            chk("drop0", bus0.oDROP_CNT, 0);
            chk("drop1", bus1.oDROP_CNT, drop_m);
            acc = valid && !busy_m;
            ewe = acc ? (4'b0001 << n_m[1:0]) : 4'b0000;
            chk("we0", bus0.oWE, ewe);
            chk("we1", bus1.oWE, ewe);
            if (acc) begin
                chk("wr_addr", bus0.oADDR_WR, n_m >> 2);
                chk("wr_data", bus0.oDATA, sx(sample));
                e.k = n_m; e.d = sx(sample);
                exp_q.push_back(e);
            end
            if (bus0.oFFT_START || start_next) chk("fft_start", bus0.oFFT_START, start_next);
            if (start_next) start_cnt++;
            start_next = acc && (n_m == 4'd15);
            if (busy_m && valid) drop_m = (drop_m >= 3) ? 3 : drop_m + 1;
            if (acc) n_m = n_m + 4'd1;
            if (!busy_m) chk("src_load", bus0.oSOURCE_CONT, 1);
            else if (unload_m) chk("src_unload", bus0.oSOURCE_CONT, 1);
            else if (!bus0.oSOURCE_CONT) lowcnt++;
            else begin
                chk("run_len", lowcnt, exp_low);
                lowcnt = 0; unload_m = 1'b1; ucyc = 0;
            end
            if (unload_m && full_tp) chk("tp_valid", bus0.oOUT_VALID, (ucyc >= 2 && ucyc < 18));
            if (unload_m) ucyc++;
            else chk("no_valid", bus0.oOUT_VALID, 0);
            if (bus0.oOUT_VALID) begin
                if (hold_v) begin
                    chk("hold_data", bus0.oOUT_DATA, hold_d);
                    chk("hold_idx", bus0.oOUT_INDEX, hold_i);
                end
                if (out_ready) begin
                    hold_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL out_extra: got index %0d, expected no output", bus0.oOUT_INDEX);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_idx", bus0.oOUT_INDEX, e.k);
                        chk("out_data", bus0.oOUT_DATA, e.d);
                        chk("out_last", bus0.oOUT_LAST, e.k == 4'd15);
                        pops++;
                        last_pop = (e.k == 4'd15);
                    end
                end else begin
                    hold_v = 1'b1; hold_d = bus0.oOUT_DATA; hold_i = bus0.oOUT_INDEX;
                end
            end else if (hold_v) begin
                chk("valid_held", bus0.oOUT_VALID, 1);
                hold_v = 1'b0;
            end
            if (start_next) busy_m = 1'b1;
            if (last_pop) begin
                busy_m = 1'b0; unload_m = 1'b0; pops = 0; frames_done++;
            end
        end
    end

    task automatic do_reset();
        valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // kind 0: samples -1,-2,..; d: FFT done delay (0 = stale ready kept high)
    task automatic run_frame(input int kind, input int d, input int rdy_pct, input int gap_pct,
                             input int abort_n, input int abort_pops);
        int done0 = frames_done;
        int seen = start_cnt;
        int fw = 0;
        int cyc = 0;
        exp_low = (d == 0) ? 3 : d + 2;
        full_tp = (rdy_pct >= 100);
        while (frames_done == done0 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (abort_n >= 0 && !busy_m && n_m == 4'(abort_n)) begin
                do_reset();
                return;
            end
            if (abort_pops >= 0 && unload_m && pops == abort_pops) begin
                do_reset();
                return;
            end
            if ($urandom_range(99) >= gap_pct) begin
                valid = 1'b1;
                sample = (kind == 0) ? -(16'(n_m) + 16'sd1) : 16'($urandom);
            end else begin
                valid = 1'b0;
            end
            out_ready = ($urandom_range(99) < rdy_pct);
            if (start_cnt != seen) begin
                seen = start_cnt;
                fw = d;
                if (d > 0) fft_rdy = 1'b0;
            end else if (fw > 0) begin
                fw--;
                if (fw == 0) fft_rdy = 1'b1;
            end
        end
        if (frames_done == done0) begin
            checks++; errors++;
            $display("FAIL frame_timeout: got no completed frame after %0d cycles, expected one", cyc);
        end
    endtask

    initial begin
        valid = 1'b0; sample = 16'sd0; fft_rdy = 1'b1; out_ready = 1'b0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_frame(0, 0, 100, 0, -1, -1);
        run_frame(1, 6, 50, 30, -1, -1);
        run_frame(1, 0, 50, 0, -1, -1);
        run_frame(1, 0, 100, 20, 7, -1);
        run_frame(1, 3, 70, 10, -1, -1);
        run_frame(1, 0, 40, 0, -1, 5);
        run_frame(0, 2, 100, 0, -1, -1);
        run_frame(1, 1, 60, 40, -1, -1);
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
